// File: rtl/turfio_cout_tx.sv
// COUT link transmitter: frames 32-bit response words into 8 nibbles (MSB first),
// fills with idle words, sends a training pattern on request and realigns on sync.
module turfio_cout_tx #(
    parameter logic [31:0] IDLE_WORD     = 32'h0000_0000,
    parameter logic [31:0] TRAIN_PATTERN = 32'hA55A_6996,
    parameter int          COUNT_WIDTH   = 16
) (
    input  logic                   rxclk_i,
    input  logic                   rst_i,
    input  logic                   train_en_i,
    input  logic                   sync_i,
    input  logic [31:0]            s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [3:0]             cout_data_o,
    output logic                   frame_start_o,
    output logic                   sync_err_o,
    input  logic                   sync_err_clr_i,
    output logic [COUNT_WIDTH-1:0] word_count_o
);

    logic [2:0]             cnt_q, cnt_d;
    logic [31:0]            shreg_q, shreg_d;
    logic                   frame_start_q, frame_start_d;
    logic                   sync_err_q, sync_err_d;
    logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;
    logic                   boundary_s;
    logic                   handshake_s;

    assign boundary_s    = (cnt_q == 3'd7);
    assign s_tready      = boundary_s && !train_en_i && !rst_i;
    assign handshake_s   = s_tready && s_tvalid;
    assign cout_data_o   = shreg_q[31:28];
    assign frame_start_o = frame_start_q;
    assign sync_err_o    = sync_err_q;
    assign word_count_o  = word_count_q;

    // Next-state: phase counter with sync realignment, frame load/shift, counters.
    always_comb begin
        cnt_d         = cnt_q + 3'd1;
        sync_err_d    = sync_err_q;
        shreg_d       = {shreg_q[27:0], 4'h0};
        frame_start_d = boundary_s;
        word_count_d  = word_count_q;

        // An off-boundary sync forces the next cycle to be a boundary; set beats clear.
        if (sync_i && (cnt_q != 3'd6)) begin
            cnt_d      = 3'd7;
            sync_err_d = 1'b1;
        end else if (sync_err_clr_i) begin
            sync_err_d = 1'b0;
        end else begin
            sync_err_d = sync_err_q;
        end

        if (boundary_s) begin
            if (train_en_i) begin
                shreg_d = TRAIN_PATTERN;
            end else if (s_tvalid) begin
                shreg_d = s_tdata;
            end else begin
                shreg_d = IDLE_WORD;
            end
        end else begin
            shreg_d = {shreg_q[27:0], 4'h0};
        end

        if (handshake_s) begin
            word_count_d = word_count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            word_count_d = word_count_q;
        end
    end

    // State registers with synchronous reset; first cycle after reset is a boundary.
    always_ff @(posedge rxclk_i) begin
        if (rst_i) begin
            cnt_q         <= 3'd7;
            shreg_q       <= IDLE_WORD;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
            word_count_q  <= {COUNT_WIDTH{1'b0}};
        end else begin
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            frame_start_q <= frame_start_d;
            sync_err_q    <= sync_err_d;
            word_count_q  <= word_count_d;
        end
    end

endmodule

// File: tb/tb_turfio_cout_tx.sv
// Bench for turfio_cout_tx: directed table, hand sequences and random stimulus
// checked every cycle against a nibble-queue reference model.
module tb_turfio_cout_tx;

    localparam logic [31:0] IDLE  = 32'h0000_0000;
    localparam logic [31:0] TRAIN = 32'hA55A_6996;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        train_en = 1'b0;
    logic        sync = 1'b0;
    logic [31:0] tdata = 32'h0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [3:0]  cout;
    logic        fs;
    logic        serr;
    logic        sclr = 1'b0;
    logic [15:0] wc;

    always #5 clk = ~clk;

    turfio_cout_tx dut (
        .rxclk_i        (clk),
        .rst_i          (rst),
        .train_en_i     (train_en),
        .sync_i         (sync),
        .s_tdata        (tdata),
        .s_tvalid       (tvalid),
        .s_tready       (tready),
        .cout_data_o    (cout),
        .frame_start_o  (fs),
        .sync_err_o     (serr),
        .sync_err_clr_i (sclr),
        .word_count_o   (wc)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // reference model: frame phase, queue of nibbles still to go on the wire
    int          m_phase;
    logic [3:0]  m_q[$];
    bit          m_fs;
    bit          m_err;
    int unsigned m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load_q(input logic [31:0] w);
        m_q.delete();
        for (int i = 7; i >= 0; i--) m_q.push_back(w[4*i +: 4]);
    endtask

    task automatic model_step();
        bit boundary;
        if (rst) begin
            m_phase = 7;
            load_q(IDLE);
            m_fs  = 1'b0;
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            boundary = (m_phase == 7);
            if (boundary) begin
                if (train_en)    load_q(TRAIN);
                else if (tvalid) begin
                    load_q(tdata);
                    m_cnt = (m_cnt + 1) % 65536;
                end
                else             load_q(IDLE);
                m_fs = 1'b1;
            end else begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                m_fs = 1'b0;
            end
            if (sync && m_phase != 6) begin
                m_phase = 7;
                m_err   = 1'b1;
            end else begin
                m_phase = (m_phase + 1) % 8;
                if (sclr) m_err = 1'b0;
            end
        end
    endtask

    // inputs are set at the falling edge; check, clock, advance model
    task automatic tick();
        logic [3:0] exp_nib;
        #1;
        if (chk_en) begin
            exp_nib = (m_q.size() > 0) ? m_q[0] : 4'h0;
            chk("cout_data", {28'h0, cout}, {28'h0, exp_nib});
            chk("frame_start", {31'h0, fs}, {31'h0, m_fs});
            chk("sync_err", {31'h0, serr}, {31'h0, m_err});
            chk("word_count", {16'h0, wc}, m_cnt & 32'hFFFF);
            chk("s_tready", {31'h0, tready},
                {31'h0, (m_phase == 7) && !train_en && !rst});
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic goto_phase(input int p);
        int n = 0;
        while (m_phase != p && n < 20) begin
            tick();
            n++;
        end
        chk("goto_phase", m_phase, p);
    endtask

    task automatic do_reset();
        rst = 1'b1; tvalid = 1'b0; train_en = 1'b0; sync = 1'b0; sclr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic [3:0]  cout;
        logic        fs;
        logic        rdy;
        logic [15:0] wc;
    } vec_t;

    vec_t tbl[10];
    logic [31:0] words[3];

    initial begin
        // one word right after reset release; boundary is cycle 0
        tbl[0] = '{1'b1, 32'h1234_5678, 4'h0, 1'b0, 1'b1, 16'd0};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{1'b0, 32'h0, 4'(i), (i == 1), (i == 8), 16'd1};
        tbl[9] = '{1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 16'd1};
        words[0] = 32'hDEAD_BEEF;
        words[1] = 32'hCAFE_F00D;
        words[2] = 32'h0123_4567;

        @(negedge clk);
        tick();                  // first edge: DUT state unknown before it
        chk_en = 1'b1;
        do_reset();

        // idle after reset (table also covers the single-word case)
        for (int i = 0; i < 10; i++) begin
            tvalid = tbl[i].valid;
            tdata  = tbl[i].data;
            #1;
            chk("tbl_cout", {28'h0, cout}, {28'h0, tbl[i].cout});
            chk("tbl_fs", {31'h0, fs}, {31'h0, tbl[i].fs});
            chk("tbl_rdy", {31'h0, tready}, {31'h0, tbl[i].rdy});
            chk("tbl_wc", {16'h0, wc}, {16'h0, tbl[i].wc});
            tick();
        end
        repeat (20) tick();      // idle frames

        // back-to-back words
        do_reset();
        for (int w = 0; w < 3; w++) begin
            tdata  = words[w];
            tvalid = 1'b1;
            repeat (8) tick();
        end
        tvalid = 1'b0;
        #1 chk("b2b_count", {16'h0, wc}, 32'd3);
        repeat (8) tick();

        // training raised mid data frame with data pending
        goto_phase(7);
        tvalid = 1'b1; tdata = 32'hCAFE_0001;
        tick();
        tdata = 32'h5A5A_1234;
        tick(); tick();
        train_en = 1'b1;
        repeat (21) tick();
        #1 chk("train_no_consume", {16'h0, wc}, 32'd4);
        goto_phase(2);
        train_en = 1'b0;
        goto_phase(7);
        tick();
        #1 chk("post_train_count", {16'h0, wc}, 32'd5);
        tvalid = 1'b0;
        repeat (8) tick();

        // sync handling
        goto_phase(6);
        sync = 1'b1; tick(); sync = 1'b0;
        #1 chk("aligned_sync_err", {31'h0, serr}, 32'd0);
        goto_phase(2);
        sync = 1'b1; tick(); sync = 1'b0;
        #1 chk("trunc_boundary_rdy", {31'h0, tready}, 32'd1);
        tick();
        #1 chk("trunc_fs", {31'h0, fs}, 32'd1);
        chk("trunc_err", {31'h0, serr}, 32'd1);
        goto_phase(3);
        sync = 1'b1; sclr = 1'b1; tick(); sync = 1'b0; sclr = 1'b0;
        #1 chk("set_beats_clr", {31'h0, serr}, 32'd1);
        sclr = 1'b1; tick(); sclr = 1'b0;
        #1 chk("lone_clr", {31'h0, serr}, 32'd0);
        repeat (10) tick();

        // reset mid-frame
        goto_phase(7);
        tvalid = 1'b1; tdata = 32'hF00D_F00D;
        tick();
        tvalid = 1'b0;
        goto_phase(3);
        rst = 1'b1;
        tick();
        #1 chk("rst_cout", {28'h0, cout}, {28'h0, IDLE[31:28]});
        chk("rst_wc", {16'h0, wc}, 32'd0);
        chk("rst_fs", {31'h0, fs}, 32'd0);
        chk("rst_rdy", {31'h0, tready}, 32'd0);
        rst = 1'b0;
        #1 chk("rst_release_rdy", {31'h0, tready}, 32'd1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst    = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) train_en = ~train_en;
            tvalid = $urandom_range(0, 1);
            tdata  = $urandom;
            sync   = ($urandom_range(0, 29) == 0);
            sclr   = ($urandom_range(0, 19) == 0);
            tick();
        end

        // counter wrap: sync held at the boundary gives one handshake per cycle
        do_reset();
        tvalid = 1'b1; sync = 1'b1;
        for (int c = 0; c < 65535; c++) begin
            tdata = $urandom;
            tick();
        end
        #1 chk("wc_full", {16'h0, wc}, 32'h0000_FFFF);
        tick();
        #1 chk("wc_wrap", {16'h0, wc}, 32'h0000_0000);
        tvalid = 1'b0; sync = 1'b0;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
